// File: rtl/cardinal_pkg.sv
// Shared Cardinal core definitions: fetch state encoding, PC defaults and
// branch/NOP opcode constants.
package cardinal_pkg;

    localparam int PC_W_DEFAULT    = 32;
    localparam int PC_STEP_DEFAULT = 4;

    localparam logic [5:0] OP_BEZ  = 6'b100010;
    localparam logic [5:0] OP_BNEZ = 6'b100011;
    localparam logic [5:0] OP_NOP  = 6'b111000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_PEND = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_perf.sv
// Saturating fetch/stall/redirect event counters for pc_fetch.
// Instantiated only when PC_FETCH_PERF_EN is defined.
module pc_fetch_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    input  logic        redirect_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc);
        if (inc && (cnt != 32'hFFFF_FFFF)) begin
            return cnt + 32'd1;
        end else begin
            return cnt;
        end
    endfunction

    // Next counter values; each sticks at all-ones once it gets there.
    always_comb begin
        fetch_cnt_d    = sat_inc(fetch_cnt_q, fetch_inc);
        stall_cnt_d    = sat_inc(stall_cnt_q, stall_inc);
        redirect_cnt_d = sat_inc(redirect_cnt_q, redirect_inc);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q    <= 32'd0;
            stall_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign fetch_cnt    = fetch_cnt_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: rtl/pc_fetch.sv
// Cardinal instruction-fetch stage: PC register, branch redirect (also under stall)
// and IF/ID flush generation. Define PC_FETCH_PERF_EN to add event counters.
module pc_fetch
    import cardinal_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter int              PC_STEP  = PC_STEP_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [15:0]     br_target,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_en,
    output logic            flush,
    output logic            pc_valid
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     redirect_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     pend_target_q, pend_target_d;
    logic            pc_valid_q;
    logic            pc_valid_s;
    logic            flush_s;
    logic [PC_W-1:0] br_target_ext_s;
    logic [PC_W-1:0] pend_target_ext_s;

    assign br_target_ext_s   = {{(PC_W-16){1'b0}}, br_target};
    assign pend_target_ext_s = {{(PC_W-16){1'b0}}, pend_target_q};

    // The reset cycle itself already reads as not-running.
    assign pc_valid_s = pc_valid_q & ~rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= 16'd0;
            pc_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pc_valid_q    <= 1'b1;
        end
    end

    // Next-state and next-PC logic; a redirect is applied only with stall low.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        if (pc_valid_s) begin
            case (state_q)
                ST_RUN, ST_HOLD: begin
                    if (br_taken && stall) begin
                        pend_target_d = br_target;
                        state_d       = ST_PEND;
                    end else if (br_taken) begin
                        pc_d    = br_target_ext_s;
                        state_d = ST_RUN;
                    end else if (stall) begin
                        state_d = ST_HOLD;
                    end else begin
                        pc_d    = pc_q + PC_W'(PC_STEP);
                        state_d = ST_RUN;
                    end
                end
                ST_PEND: begin
                    if (stall) begin
                        if (br_taken) begin
                            pend_target_d = br_target;
                        end else begin
                            pend_target_d = pend_target_q;
                        end
                    end else begin
                        pc_d    = br_taken ? br_target_ext_s : pend_target_ext_s;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Flush marks the cycle in which a redirect is applied.
    always_comb begin
        flush_s = 1'b0;
        if (pc_valid_s && !stall) begin
            case (state_q)
                ST_PEND:         flush_s = 1'b1;
                ST_RUN, ST_HOLD: flush_s = br_taken;
                default:         flush_s = 1'b0;
            endcase
        end else begin
            flush_s = 1'b0;
        end
    end

    assign imem_addr = pc_q;
    assign imem_en   = pc_valid_s & ~stall;
    assign flush     = flush_s;
    assign pc_valid  = pc_valid_s;

`ifdef PC_FETCH_PERF_EN
    pc_fetch_perf u_perf (
        .clk          (clk),
        .rst          (rst),
        .fetch_inc    (imem_en & ~flush_s),
        .stall_inc    (stall),
        .redirect_inc (flush_s),
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a cycle-level fetch model predicts each cycle's
// outputs; a monitor compares them against the DUT between clock edges.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'd0;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic        flush;
    logic        pc_valid;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt, redirect_cnt;
`endif

    pc_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem_addr (imem_addr),
        .imem_en   (imem_en),
        .flush     (flush),
        .pc_valid  (pc_valid)
`ifdef PC_FETCH_PERF_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        flush;
        logic        en;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] sc;
        logic [31:0] rc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 1'b0;

    // Reference model: architectural PC, an optional pending redirect, running flag.
    logic [31:0] m_pc = 32'd0;
    bit          m_pend = 1'b0;
    logic [15:0] m_pend_tgt = 16'd0;
    bit          m_valid = 1'b0;
    logic [31:0] m_fc = 32'd0, m_sc = 32'd0, m_rc = 32'd0;

    function automatic logic [31:0] sat(input logic [31:0] v, input bit inc);
        return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    task automatic cyc(input bit r, input bit s, input bit b, input logic [15:0] t);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; br_taken = b; br_target = t;
        e.valid = m_valid && !r;
        e.addr  = m_pc;
        e.en    = e.valid && !s;
        e.flush = e.valid && !s && (b || m_pend);
        e.fc = m_fc; e.sc = m_sc; e.rc = m_rc;
        exp_q.push_back(e);
        if (r) begin
            m_pc = 32'd0; m_pend = 1'b0; m_pend_tgt = 16'd0; m_valid = 1'b0;
            m_fc = 32'd0; m_sc = 32'd0; m_rc = 32'd0;
        end else begin
            m_fc = sat(m_fc, e.en && !e.flush);
            m_sc = sat(m_sc, s);
            m_rc = sat(m_rc, e.flush);
            if (e.valid) begin
                if (e.flush) begin
                    m_pc   = {16'd0, (b ? t : m_pend_tgt)};
                    m_pend = 1'b0;
                end else if (s && b) begin
                    m_pend     = 1'b1;
                    m_pend_tgt = t;
                end else if (!s) begin
                    m_pc = m_pc + 32'd4;
                end
            end
            m_valid = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle, between the driving and sampling edges, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) begin
                if (!stim_done) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_empty at %0t", $time);
                end
            end else begin
                e = exp_q.pop_front();
                chk("pc_valid",  {31'd0, pc_valid}, {31'd0, e.valid});
                chk("imem_addr", imem_addr, e.addr);
                chk("imem_en",   {31'd0, imem_en}, {31'd0, e.en});
                chk("flush",     {31'd0, flush}, {31'd0, e.flush});
`ifdef PC_FETCH_PERF_EN
                chk("fetch_cnt",    fetch_cnt, e.fc);
                chk("stall_cnt",    stall_cnt, e.sc);
                chk("redirect_cnt", redirect_cnt, e.rc);
`endif
            end
        end
    end

    initial begin
        int k;
        // Reset, then plain sequential fetch up to pc=8.
        cyc(1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        // Taken branch at pc=8 to 0x40, then sequential.
        cyc(1'b0, 1'b0, 1'b1, 16'h0040);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        // Three-cycle stall then release.
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        // Redirect under stall, stall held two more cycles.
        cyc(1'b0, 1'b1, 1'b1, 16'h0100);
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        // Two redirects in one stall window; the later one wins.
        cyc(1'b0, 1'b1, 1'b1, 16'h0020);
        cyc(1'b0, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0080);
        cyc(1'b0, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        // Reset while a redirect is pending.
        cyc(1'b0, 1'b1, 1'b1, 16'h0200);
        cyc(1'b1, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        // Randomized traffic.
        for (k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 35),
                ($urandom_range(0, 99) < 25),
                16'($urandom));
        end
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        stim_done = 1'b1;
        #5;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the five-stage Cardinal core. Holds the program counter and drives the instruction-memory address. Applies branch redirects resolved in decode, including redirects that arrive while the pipeline is stalled. Produces the flush that kills the wrong-path instruction entering the IF/ID register. The instruction memory reads asynchronously; its data goes straight into the IF/ID decoder.

## Interface
- PC_W, 32, program-counter width
- PC_STEP, 4, sequential increment (byte addressing, 32-bit instructions)
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hazard unit: hold PC; IF/ID also holds
- br_taken  in  1  decode resolved a BEZ/BNEZ as taken this cycle
- br_target  in  16  absolute branch target (the decoded immediate)
- imem_addr  out  PC_W  instruction-memory read address (= pc)
- imem_en  out  1  instruction-memory read enable
- flush  out  1  kill the instruction now fetched (to IF/ID flush)
- pc_valid  out  1  fetch is running (low during the reset cycle)

## Operation
- The next-PC target is zero-extended: {(PC_W-16)'b0, br_target}.
- State machine, one-hot or binary:
  - RUN
  - HOLD (stalled, no redirect pending)
  - PEND (stalled with a redirect latched in pend_target)
- Per-cycle priority in RUN:
  1. br_taken & stall: latch the target, pc holds, flush=0, go to PEND.
  2. br_taken: pc<=target, flush=1.
  3. stall: pc holds, go to HOLD.
  4. Otherwise pc<=pc+PC_STEP.
- HOLD:
  - stall & br_taken: latch the target, go to PEND.
  - stall only: remain in HOLD.
  - !stall: behave exactly as RUN this cycle (including br_taken), then return to RUN.
- PEND:
  - stall: remain. A newer br_taken overwrites pend_target.
  - !stall: pc<=pend_target (or br_target if br_taken is also high this cycle), flush=1, go to RUN.
- flush is combinational and high only in a cycle where a redirect is applied, so it never coincides with stall. IF/ID gives stall priority over flush, which is why a redirect is never applied while stall is high.
- PC wraps modulo 2^PC_W. No fault is raised.
- imem_en = pc_valid & !stall.

## Timing
- Reset values:
  - pc=RESET_PC, state=RUN, pend_target=0
  - pc_valid=0 during the cycle rst is sampled, 1 from the next cycle
  - flush=0, imem_en=0 while pc_valid=0
- Reset mid-PEND discards the pending redirect.
- Sequential latency: the new PC is visible on imem_addr one cycle after the edge.
- Branch penalty: one killed instruction (the one fetched in the br_taken cycle). The target instruction reaches IF/ID on the following edge.
- Redirect under stall: flush asserts in the first cycle with stall=0. The target appears on imem_addr the next cycle.
- flush, imem_en and imem_addr do not depend combinationally on imem data.

## Configuration
- PC_FETCH_PERF_EN defined adds three 32-bit saturating output counters, all cleared by rst:
  - fetch_cnt: increments on cycles with imem_en=1 and flush=0
  - stall_cnt: increments on cycles with stall=1
  - redirect_cnt: increments on cycles with flush=1
- Undefined: the counter ports and logic are absent and behaviour is otherwise identical.

## Structure
- Shared package cardinal_pkg holds:
  - the state enum (RUN/HOLD/PEND)
  - the PC_W/PC_STEP defaults
  - the opcode constants BEZ=6'b100010, BNEZ=6'b100011, NOP=6'b111000
- One sub-module, pc_fetch_perf, holds the counters. It is instantiated only under PC_FETCH_PERF_EN.

## Test plan
- Reset release, no stall: imem_addr reads 0, 4, 8, 12 on consecutive cycles. pc_valid rises one cycle after rst falls. flush stays 0.
- br_taken=1, br_target=16'h0040 at pc=8: flush=1 that cycle, and imem_addr=32'h40 next cycle, then 32'h44.
- stall held three cycles at pc=12: imem_addr stays 12 and imem_en=0, then advances to 16 on release.
- br_taken with target 16'h0100 while stall=1, stall held two more cycles: flush stays 0 during the stall. flush=1 in the first stall=0 cycle, and imem_addr=32'h100 next cycle.
- Two br_taken pulses (16'h0020, then 16'h0080) during one stall window: only 16'h0080 is applied, with exactly one flush.
- rst asserted while in PEND: imem_addr returns to RESET_PC, no flush follows, and (with PC_FETCH_PERF_EN) all counters read 0.
